an_config_rx: RTL and testbench
===============================

Name: an_config_rx

Overview:
- Receive side of SGMII / Clause-37 auto-negotiation: parses the decoded 8b/10b byte stream from the PHY link.
- Extracts /C1/ and /C2/ configuration ordered sets and /I1/ and /I2/ idle ordered sets.
- Reports each received 16-bit config word and raises ability_match, ack_match and idle_match per consecutive-match rules.
- Sits between the 8b/10b decoder and the AN arbitration FSM in the SGMII path, in the 125 MHz byte domain.

Parameters:
- MATCH_COUNT, 3: consecutive identical config words needed for ability_match / ack_match (range 2..15).
- IDLE_COUNT, 3: consecutive idle ordered sets needed for idle_match (range 2..15).

Ports:
- clock  in  1  byte clock, 125 MHz.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  qualifies rx_data/rx_is_k; state advances only when high.
- rx_data  in  8  decoded byte.
- rx_is_k  in  1  byte is a K code.
- config_word  out  16  last complete config word, {hi,lo}; holds until next word.
- config_valid  out  1  one-cycle pulse when config_word updates.
- ability_match  out  1  MATCH_COUNT consecutive words equal, ignoring bit 14 (ACK).
- ack_match  out  1  MATCH_COUNT consecutive words fully equal with bit 14 = 1.
- idle_match  out  1  IDLE_COUNT consecutive idle sets seen.
- frame_err  out  1  one-cycle pulse on malformed ordered set.

Behaviour:
- Reset (async, immediate): all outputs 0, config_word = 16'h0000, FSM = HUNT, all counters and the previous word cleared.
- With rx_valid = 0: FSM, counters and level outputs hold; pulses deassert.
- Byte codes:
  - K28.5 = 8'hBC with k = 1.
  - D21.5 = 8'hB5 and D2.2 = 8'h42 (config sets).
  - D5.6 = 8'hC5 and D16.2 = 8'h50 (idle sets).
- FSM, one transition per valid byte:
  - HUNT: K28.5 -> COMMA; any other byte stays in HUNT with no error.
  - COMMA: D21.5 or D2.2 (k = 0) -> CFG_LO.
  - COMMA: D5.6 or D16.2 (k = 0) -> HUNT and count one idle set.
  - COMMA: K28.5 -> COMMA (re-sync) with a frame_err pulse.
  - COMMA: any other byte -> HUNT with a frame_err pulse.
  - CFG_LO: byte with k = 0 is latched as the low byte -> CFG_HI; k = 1 -> frame_err and HUNT.
  - CFG_HI: byte with k = 0 completes the word -> HUNT; k = 1 -> frame_err and HUNT, word discarded.
- Word completion:
  - config_word = {rx_data, lo} and config_valid pulse are registered, visible the cycle after the 4th byte is sampled.
  - Match flags update in that same cycle.
- Ability counter (4 bits, saturates at MATCH_COUNT):
  - New word equal to the previous word with bit 14 masked: increment.
  - Otherwise: load 1.
  - ability_match = (count == MATCH_COUNT).
- Ack counter (4 bits, saturates):
  - New word fully equal to the previous word and bit 14 = 1: increment.
  - Else if bit 14 = 1: load 1.
  - Else: load 0.
  - ack_match = (count == MATCH_COUNT).
- Idle counter (4 bits, saturates):
  - Each idle set increments it.
  - Any completed config word clears it.
  - idle_match = (count == IDLE_COUNT).
- A completed idle set clears the ability and ack counters and the previous word, so ability_match and ack_match drop the cycle after the idle set's second byte.
- A frame_err does not clear the counters; the discarded partial word does not break a match run.
- Back-to-back ordered sets with no gap are supported; no bubble cycles are required.

Test Plan:
- Reset, then 3× /C1/ words 16'h4001 (bytes BC, B5, 01, 40): config_valid pulses 3×, config_word = 16'h4001. ability_match and ack_match both rise after the 3rd word; idle_match = 0.
- Alternating /C1/ and /C2/ of 16'h0001 then 16'h4001 repeated: ability_match rises after the 3rd word (ACK masked). ack_match rises only after 3 consecutive 16'h4001.
- Matched state, then 3× /I2/ (BC, 50): ability_match and ack_match fall after the 1st idle; idle_match = 1 after the 3rd idle.
- Malformed sets BC, 7C(k = 1) and BC, B5, 3C(k = 1): a frame_err pulse for each. No config_valid; the following valid word is decoded correctly.
- rx_valid gaps of 1–3 cycles inserted mid-word: word decoded identically, with no extra pulses.
- Async reset asserted between CFG_LO and CFG_HI: all outputs immediately 0. The next full /C1/ decodes, with ability count = 1.

Source files
------------

// File: rtl/an_config_rx.sv
// ---------------------------------------------------------------------------
// an_config_rx
// Receive side of SGMII / Clause-37 auto-negotiation. Parses the decoded
// 8b/10b byte stream and extracts /C1/,/C2/ configuration ordered sets and
// /I1/,/I2/ idle ordered sets. Reports each completed 16-bit config word and
// tracks the consecutive-match conditions used by the AN arbitration FSM.
//
// Ports:
//   clock          in   byte clock (125 MHz)
//   reset          in   asynchronous, active-high reset
//   rx_valid       in   qualifies rx_data / rx_is_k
//   rx_data[7:0]   in   decoded byte
//   rx_is_k        in   byte is a K code
//   config_word    out  last complete config word {hi,lo}
//   config_valid   out  one-cycle pulse when config_word updates
//   ability_match  out  MATCH_COUNT consecutive words equal (ACK bit ignored)
//   ack_match      out  MATCH_COUNT consecutive identical words with ACK set
//   idle_match     out  IDLE_COUNT consecutive idle sets seen
//   frame_err      out  one-cycle pulse on a malformed ordered set
// ---------------------------------------------------------------------------
module an_config_rx #(
  parameter int unsigned MATCH_COUNT = 3,
  parameter int unsigned IDLE_COUNT  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_is_k,
  output logic [15:0] config_word,
  output logic        config_valid,
  output logic        ability_match,
  output logic        ack_match,
  output logic        idle_match,
  output logic        frame_err
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_COMMA  = 2'd1;
  localparam logic [1:0] ST_CFG_LO = 2'd2;
  localparam logic [1:0] ST_CFG_HI = 2'd3;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;

  localparam logic [3:0]  MATCH_LIM = 4'(MATCH_COUNT);
  localparam logic [3:0]  IDLE_LIM  = 4'(IDLE_COUNT);
  // Bit 14 is the ACK bit; ability comparison ignores it.
  localparam logic [15:0] ACK_MASK  = 16'hBFFF;

  // Counters stop at their limit so a long run keeps the match flag asserted.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt, input logic [3:0] lim);
    logic [3:0] res;
    if (cnt >= lim) begin
      res = cnt;
    end else begin
      res = cnt + 4'd1;
    end
    return res;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] prev_q, prev_d;
  logic [3:0]  abil_cnt_q, abil_cnt_d;
  logic [3:0]  ack_cnt_q, ack_cnt_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;
  logic [15:0] word_q, word_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic        ferr_q, ferr_d;
  logic        abil_match_q, ack_match_q, idle_match_q;

  logic        is_comma;
  logic        word_done;
  logic        idle_done;
  logic [15:0] new_word;

  assign is_comma = rx_is_k && (rx_data == K28_5);
  assign new_word = {rx_data, lo_q};

  // Ordered-set parser: one transition per valid byte.
  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    ferr_d    = 1'b0;
    word_done = 1'b0;
    idle_done = 1'b0;
    if (rx_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (is_comma) begin
            state_d = ST_COMMA;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_COMMA: begin
          if (!rx_is_k && ((rx_data == D21_5) || (rx_data == D2_2))) begin
            state_d = ST_CFG_LO;
          end else if (!rx_is_k && ((rx_data == D5_6) || (rx_data == D16_2))) begin
            state_d   = ST_HUNT;
            idle_done = 1'b1;
          end else if (is_comma) begin
            // A fresh comma re-synchronises onto the new ordered set.
            state_d = ST_COMMA;
            ferr_d  = 1'b1;
          end else begin
            state_d = ST_HUNT;
            ferr_d  = 1'b1;
          end
        end
        ST_CFG_LO: begin
          if (!rx_is_k) begin
            lo_d    = rx_data;
            state_d = ST_CFG_HI;
          end else begin
            state_d = ST_HUNT;
            ferr_d  = 1'b1;
          end
        end
        ST_CFG_HI: begin
          if (!rx_is_k) begin
            word_done = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = ST_HUNT;
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Word capture and consecutive-match counters.
  always_comb begin
    word_d      = word_q;
    cfg_valid_d = 1'b0;
    prev_d      = prev_q;
    abil_cnt_d  = abil_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    if (word_done) begin
      word_d      = new_word;
      cfg_valid_d = 1'b1;
      prev_d      = new_word;
      idle_cnt_d  = 4'd0;
      if ((new_word & ACK_MASK) == (prev_q & ACK_MASK)) begin
        abil_cnt_d = sat_inc(abil_cnt_q, MATCH_LIM);
      end else begin
        abil_cnt_d = 4'd1;
      end
      if ((new_word == prev_q) && new_word[14]) begin
        ack_cnt_d = sat_inc(ack_cnt_q, MATCH_LIM);
      end else if (new_word[14]) begin
        ack_cnt_d = 4'd1;
      end else begin
        ack_cnt_d = 4'd0;
      end
    end else if (idle_done) begin
      // Idle breaks any config run; the next word starts from scratch.
      prev_d     = 16'h0000;
      abil_cnt_d = 4'd0;
      ack_cnt_d  = 4'd0;
      idle_cnt_d = sat_inc(idle_cnt_q, IDLE_LIM);
    end else begin
      idle_cnt_d = idle_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      lo_q         <= 8'h00;
      prev_q       <= 16'h0000;
      abil_cnt_q   <= 4'd0;
      ack_cnt_q    <= 4'd0;
      idle_cnt_q   <= 4'd0;
      word_q       <= 16'h0000;
      cfg_valid_q  <= 1'b0;
      ferr_q       <= 1'b0;
      abil_match_q <= 1'b0;
      ack_match_q  <= 1'b0;
      idle_match_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_q         <= lo_d;
      prev_q       <= prev_d;
      abil_cnt_q   <= abil_cnt_d;
      ack_cnt_q    <= ack_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      word_q       <= word_d;
      cfg_valid_q  <= cfg_valid_d;
      ferr_q       <= ferr_d;
      abil_match_q <= (abil_cnt_d == MATCH_LIM);
      ack_match_q  <= (ack_cnt_d == MATCH_LIM);
      idle_match_q <= (idle_cnt_d == IDLE_LIM);
    end
  end

  assign config_word   = word_q;
  assign config_valid  = cfg_valid_q;
  assign ability_match = abil_match_q;
  assign ack_match     = ack_match_q;
  assign idle_match    = idle_match_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_an_config_rx.sv
// ---------------------------------------------------------------------------
// tb_an_config_rx
// Directed scenarios plus randomized ordered-set traffic for an_config_rx.
// The reference model tracks the parse position within an ordered set and a
// history of completed words; match flags are derived from run lengths over
// that history.
// ---------------------------------------------------------------------------
module tb_an_config_rx;

  localparam int M  = 3;
  localparam int IC = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_is_k;
  logic [15:0] config_word;
  logic        config_valid;
  logic        ability_match;
  logic        ack_match;
  logic        idle_match;
  logic        frame_err;

  an_config_rx #(.MATCH_COUNT(M), .IDLE_COUNT(IC)) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_is_k      (rx_is_k),
    .config_word  (config_word),
    .config_valid (config_valid),
    .ability_match(ability_match),
    .ack_match    (ack_match),
    .idle_match   (idle_match),
    .frame_err    (frame_err)
  );

  always #4 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_pos;        // bytes of the current ordered set accepted so far
  logic [7:0]  m_lo;
  logic [15:0] hist[$];      // words received since the last idle / reset
  int          idle_run;     // idle sets since the last word / reset
  logic [15:0] e_word;
  logic        e_cv, e_ab, e_ack, e_idle, e_ferr;

  task automatic m_reset();
    m_pos = 0; m_lo = 8'h00; hist.delete(); idle_run = 0;
    e_word = 16'h0000; e_cv = 1'b0; e_ab = 1'b0; e_ack = 1'b0; e_idle = 1'b0; e_ferr = 1'b0;
  endtask

  task automatic m_flags();
    int n;
    logic [15:0] last;
    n = hist.size();
    e_ab  = 1'b0;
    e_ack = 1'b0;
    if (n >= M) begin
      last  = hist[n-1];
      e_ab  = 1'b1;
      e_ack = last[14];
      for (int i = 0; i < M; i++) begin
        if ((hist[n-1-i] & 16'hBFFF) != (last & 16'hBFFF)) e_ab = 1'b0;
        if (hist[n-1-i] != last) e_ack = 1'b0;
      end
    end
    e_idle = (idle_run >= IC);
  endtask

  task automatic m_byte(input logic v, input logic k, input logic [7:0] d);
    logic comma;
    e_cv   = 1'b0;
    e_ferr = 1'b0;
    comma  = k && (d == 8'hBC);
    if (v) begin
      if (m_pos == 0) begin
        if (comma) m_pos = 1;
      end else if (m_pos == 1) begin
        if (!k && (d == 8'hB5 || d == 8'h42)) m_pos = 2;
        else if (!k && (d == 8'hC5 || d == 8'h50)) begin
          m_pos = 0; hist.delete(); idle_run++;
        end else if (comma) e_ferr = 1'b1;
        else begin e_ferr = 1'b1; m_pos = 0; end
      end else if (m_pos == 2) begin
        if (!k) begin m_lo = d; m_pos = 3; end
        else begin e_ferr = 1'b1; m_pos = 0; end
      end else begin
        if (!k) begin
          e_word = {d, m_lo}; e_cv = 1'b1;
          hist.push_back({d, m_lo}); idle_run = 0;
          if (hist.size() > 16) void'(hist.pop_front());
        end else e_ferr = 1'b1;
        m_pos = 0;
      end
      m_flags();
    end
  endtask

  task automatic check_all();
    check_val("config_word",   config_word,            e_word);
    check_val("config_valid",  {15'h0, config_valid},  {15'h0, e_cv});
    check_val("ability_match", {15'h0, ability_match}, {15'h0, e_ab});
    check_val("ack_match",     {15'h0, ack_match},     {15'h0, e_ack});
    check_val("idle_match",    {15'h0, idle_match},    {15'h0, e_idle});
    check_val("frame_err",     {15'h0, frame_err},     {15'h0, e_ferr});
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic v, input logic k, input logic [7:0] d);
    rx_valid = v; rx_is_k = k; rx_data = d;
    @(posedge clock);
    m_byte(v, k, d);
    @(negedge clock);
    check_all();
  endtask

  task automatic byte_g(input logic k, input logic [7:0] d, input int maxgap);
    int g;
    g = $urandom_range(maxgap, 0);
    for (int i = 0; i < g; i++) cyc(1'b0, 1'($urandom), 8'($urandom));
    cyc(1'b1, k, d);
  endtask

  task automatic send_cfg(input logic [15:0] w, input int gap);
    byte_g(1'b1, 8'hBC, gap);
    byte_g(1'b0, ($urandom_range(1, 0) == 1) ? 8'hB5 : 8'h42, gap);
    byte_g(1'b0, w[7:0], gap);
    byte_g(1'b0, w[15:8], gap);
  endtask

  task automatic send_idle(input logic [7:0] code, input int gap);
    byte_g(1'b1, 8'hBC, gap);
    byte_g(1'b0, code, gap);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [15:0] pool [4];
    logic [15:0] w;
    int sel;
    pool[0] = 16'h4001; pool[1] = 16'h0001; pool[2] = 16'h4000; pool[3] = 16'h01A0;

    reset = 1'b1; rx_valid = 1'b0; rx_is_k = 1'b0; rx_data = 8'h00;
    m_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b0;

    // Three identical /C1/ words with ACK set.
    for (int i = 0; i < 3; i++) send_cfg(16'h4001, 0);
    check_val("dir_word",  config_word, 16'h4001);
    check_val("dir_abil",  {15'h0, ability_match}, 16'h0001);
    check_val("dir_ack",   {15'h0, ack_match},     16'h0001);
    check_val("dir_idle0", {15'h0, idle_match},    16'h0000);

    // Idle sets drop the config matches and build idle_match.
    send_idle(8'h50, 0);
    check_val("idle1_abil", {15'h0, ability_match}, 16'h0000);
    check_val("idle1_ack",  {15'h0, ack_match},     16'h0000);
    send_idle(8'h50, 0);
    send_idle(8'h50, 0);
    check_val("idle3_idle", {15'h0, idle_match},    16'h0001);

    // Alternating ACK bit: ability matches, ack does not until a clean run.
    send_cfg(16'h0001, 0); send_cfg(16'h4001, 0); send_cfg(16'h0001, 0);
    check_val("alt_abil", {15'h0, ability_match}, 16'h0001);
    check_val("alt_ack",  {15'h0, ack_match},     16'h0000);
    check_val("alt_idle", {15'h0, idle_match},    16'h0000);
    for (int i = 0; i < 3; i++) send_cfg(16'h4001, 0);
    check_val("run_ack",  {15'h0, ack_match},     16'h0001);

    // Malformed sets: comma followed by a K byte, and K byte in the low slot.
    cyc(1'b1, 1'b1, 8'hBC); cyc(1'b1, 1'b1, 8'h7C);
    check_val("mal1_ferr", {15'h0, frame_err}, 16'h0001);
    cyc(1'b1, 1'b1, 8'hBC); cyc(1'b1, 1'b0, 8'hB5); cyc(1'b1, 1'b1, 8'h3C);
    check_val("mal2_ferr", {15'h0, frame_err}, 16'h0001);
    send_cfg(16'h4001, 0);
    check_val("mal_abil_kept", {15'h0, ability_match}, 16'h0001);

    // Gaps mid-word.
    send_cfg(16'h4001, 3);
    check_val("gap_word", config_word, 16'h4001);

    // Asynchronous reset between the low and high bytes.
    cyc(1'b1, 1'b1, 8'hBC); cyc(1'b1, 1'b0, 8'hB5); cyc(1'b1, 1'b0, 8'h01);
    rx_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    m_reset();
    check_all();
    @(negedge clock);
    reset = 1'b0;
    send_cfg(16'h4001, 0);
    check_val("rst_word", config_word, 16'h4001);
    check_val("rst_abil", {15'h0, ability_match}, 16'h0000);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(9, 0);
      if (sel < 5) begin
        w = ($urandom_range(4, 0) == 0) ? 16'($urandom) : pool[$urandom_range(3, 0)];
        send_cfg(w, 2);
      end else if (sel < 7) begin
        send_idle(($urandom_range(1, 0) == 1) ? 8'hC5 : 8'h50, 2);
      end else if (sel == 7) begin
        byte_g(1'b1, 8'hBC, 1); byte_g(1'($urandom), 8'($urandom), 1);
      end else if (sel == 8) begin
        byte_g(1'b1, 8'hBC, 1); byte_g(1'b0, 8'hB5, 1);
        byte_g(1'b0, 8'($urandom), 1); byte_g(1'b1, 8'($urandom), 1);
      end else begin
        byte_g(1'($urandom), 8'($urandom), 2);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
